// File: rtl/bcd_display_driver.sv
// Sequential double-dabble converter driving four active-low seven-segment digits.
// One shift-add-3 step per cycle; bcd and hex outputs only change on done.
module bcd_display_driver #(
    parameter int IN_WIDTH      = 11,
    parameter int DIGITS        = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   value,
    input  logic                  value_valid,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam longint MAX_IN  = (longint'(1) << IN_WIDTH) - 1;
    localparam longint MAX_OUT = (longint'(10) ** DIGITS) - 1;

    if (DIGITS != 4) begin : g_bad_digits
        $error("bcd_display_driver: DIGITS must be 4");
    end
    if (MAX_IN > MAX_OUT) begin : g_bad_width
        $error("bcd_display_driver: IN_WIDTH too wide for DIGITS");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [BW-1:0]       adj, shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                done_q, done_d;
    logic [27:0]         hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digits above the most significant non-zero one go blank; digit 0 never does.
    function automatic logic [27:0] disp(input logic [15:0] b);
        logic [27:0] h;
        logic        lead;
        lead = 1'b1;
        h    = '0;
        for (int i = 3; i >= 0; i--) begin
            if (BLANK_LEADING && lead && i != 0 && b[4*i +: 4] == 4'd0) begin
                h[7*i +: 7] = 7'h7F;
            end else begin
                lead        = 1'b0;
                h[7*i +: 7] = seg7(b[4*i +: 4]);
            end
        end
        return h;
    endfunction

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[BW-2:0], bin_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    bin_d     = value;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bin_d     = bin_q << 1;
                scratch_d = shifted;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        hex_d = disp(16'(bcd_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            hex_q     <= disp(16'h0000);
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            hex_q     <= hex_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign hex0 = hex_q[6:0];
    assign hex1 = hex_q[13:7];
    assign hex2 = hex_q[20:14];
    assign hex3 = hex_q[27:21];

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: latency, busy window,
// dropped requests, back-to-back throughput and reset abort.
module tb_bcd_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] value;
    logic        value_valid;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks   = 0;
    int failures = 0;

    bcd_display_driver dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e3,
                             input logic [6:0] e2, input logic [6:0] e1,
                             input logic [6:0] e0);
        check({tag, ".hex3"}, 32'(hex3), 32'(e3));
        check({tag, ".hex2"}, 32'(hex2), 32'(e2));
        check({tag, ".hex1"}, 32'(hex1), 32'(e1));
        check({tag, ".hex0"}, 32'(hex0), 32'(e0));
    endtask

    // Pulse value_valid for one cycle; returns at the negedge after E0.
    task automatic start(input logic [10:0] v);
        value       = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    // Wait (bounded) for done; cyc counts negedges since the one after E0.
    task automatic wait_done(input string tag, input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check({tag, ".timeout"}, 32'(done), 32'd1);
    endtask

    int busy_cnt, done_cnt, done_at, cyc, last_done;

    initial begin
        reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.bcd", 32'(bcd), 32'h0000);
        check_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        reset = 1'b0;
        @(negedge clk);

        // value 10: busy n1..n11, done only at n12
        start(11'd10);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int n = 1; n <= 16; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
                check("v10.bcd", 32'(bcd), 32'h0010);
                check_hex("v10", 7'h7F, 7'h7F, 7'h79, 7'h40);
            end
            @(negedge clk);
        end
        check("v10.busy_cycles", 32'(busy_cnt), 32'd11);
        check("v10.done_count", 32'(done_cnt), 32'd1);
        check("v10.done_at", 32'(done_at), 32'd12);
        check("v10.hold.bcd", 32'(bcd), 32'h0010);

        // full-scale input
        start(11'd2047);
        wait_done("v2047", 20, cyc);
        check("v2047.latency", 32'(cyc), 32'd12);
        check("v2047.bcd", 32'(bcd), 32'h2047);
        check_hex("v2047", 7'h24, 7'h40, 7'h19, 7'h78);
        @(negedge clk);
        check("v2047.done_pulse", 32'(done), 32'd0);

        // request while busy is dropped
        start(11'd5);
        done_cnt = 0;
        for (int n = 1; n <= 28; n++) begin
            value_valid = (n == 3);
            value       = (n == 3) ? 11'd999 : 11'd5;
            if (done) begin
                done_cnt++;
                check("drop.bcd", 32'(bcd), 32'h0005);
            end
            @(negedge clk);
        end
        value_valid = 1'b0;
        check("drop.done_count", 32'(done_cnt), 32'd1);
        check("drop.final_bcd", 32'(bcd), 32'h0005);
        check_hex("drop", 7'h7F, 7'h7F, 7'h7F, 7'h12);

        // value_valid held: one conversion every 12 cycles
        value       = 11'd0;
        value_valid = 1'b1;
        done_cnt    = 0;
        last_done   = 0;
        for (int n = 0; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                check("b2b.bcd", 32'(bcd), 32'(done_cnt));
                if (done_cnt > 0) check("b2b.period", 32'(n - last_done), 32'd12);
                last_done = n;
                done_cnt++;
                value = value + 11'd1;
                if (done_cnt == 3) value_valid = 1'b0;
            end
        end
        value_valid = 1'b0;
        check("b2b.done_count", 32'(done_cnt), 32'd3);

        // reset mid-conversion aborts 1999
        start(11'd1999);
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            reset = (n == 5);
            if (done) done_cnt++;
            if (n == 6) begin
                check("abort.busy", 32'(busy), 32'd0);
                check("abort.bcd", 32'(bcd), 32'h0000);
                check_hex("abort", 7'h7F, 7'h7F, 7'h7F, 7'h40);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        check("abort.done_count", 32'(done_cnt), 32'd0);
        check("abort.hold.bcd", 32'(bcd), 32'h0000);

        start(11'd100);
        wait_done("v100", 20, cyc);
        check("v100.latency", 32'(cyc), 32'd12);
        check("v100.bcd", 32'(bcd), 32'h0100);
        check_hex("v100", 7'h7F, 7'h79, 7'h40, 7'h40);

        // reset together with value_valid: request dropped
        reset       = 1'b1;
        value       = 11'd7;
        value_valid = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        value_valid = 1'b0;
        check("rstvld.busy", 32'(busy), 32'd0);
        repeat (14) @(negedge clk);
        check("rstvld.bcd", 32'(bcd), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
